imem_sync: RTL and testbench

Synchronous, parametrised instruction memory for the pipelined RISC-V core. It replaces the combinational word-indexed ROM with a registered fetch port. The fetch port takes byte addresses and uses a valid/ready handshake with stall and flush support. The block also flags misaligned and out-of-range fetches, and has a word-write load port for programming instructions at run time. It sits between the IF-stage PC register and the IF/ID pipeline register.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_array.sv | 46 ++++
 rtl/imem_sync.sv | 105 ++++++++++
 tb/tb_imem_sync.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
// The optional parity protection is enabled with IMEM_PARITY_EN.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port word array: synchronous write, registered read that holds between reads.
// With IMEM_PARITY_EN each word carries an even-parity bit checked on the read output.
module imem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata,
    output logic          o_par_err
);

`ifdef IMEM_PARITY_EN
    localparam int DW = 33;
    logic [DW-1:0] w_wr_word;
    assign w_wr_word = {^i_wdata, i_wdata};
`else
    localparam int DW = 32;
    logic [DW-1:0] w_wr_word;
    assign w_wr_word = i_wdata;
`endif

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd;

    // The read register only updates on a read so a stalled response stays put.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= w_wr_word;
        end else if (i_re) begin
            r_rd <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rd[31:0];

`ifdef IMEM_PARITY_EN
    assign o_par_err = ^r_rd;
`else
    assign o_par_err = 1'b0;
`endif

endmodule

// File: rtl/imem_sync.sv
// Registered-fetch instruction memory with valid/ready handshake, flush and load port.
// Define IMEM_PARITY_EN to add per-word parity checking on the fetch path.
module imem_sync
    import imem_pkg::*;
#(
    parameter int          DEPTH  = 1024,
    parameter int          ADDR_W = 32,
    parameter logic [31:0] NOP    = NOP_INST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_inst,
    output logic                     rsp_fault,
    input  logic                     flush,
    input  logic                     ld_valid,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data,
    output logic [15:0]              ld_count
);

    localparam int AW = $clog2(DEPTH);

    state_t        r_state;
    logic          r_use_nop;
    logic          r_addr_fault;
    logic [15:0]   r_ld_count;

    logic          w_accept;
    logic          w_misalign;
    logic          w_oor;
    logic          w_fault;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_arr_addr;
    logic [31:0]   w_rd_data;
    logic          w_par_err;

    assign fetch_ready = !ld_valid && (r_state == IDLE || (r_state == RESP && rsp_ready));
    assign w_accept    = fetch_req && fetch_ready;
    assign w_misalign  = |fetch_addr[1:0];
    assign w_rd_idx    = AW'(word_index(32'(fetch_addr)));

    // Any address bit above the array span is a fault rather than a wrap.
    generate
        if (ADDR_W > AW + 2) begin : g_range
            assign w_oor = |fetch_addr[ADDR_W-1:AW+2];
        end else begin : g_norange
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_fault    = w_misalign || w_oor;
    assign w_arr_addr = ld_valid ? ld_addr : w_rd_idx;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .i_we      (ld_valid && !rst),
        .i_re      (w_accept),
        .i_addr    (w_arr_addr),
        .i_wdata   (ld_data),
        .o_rdata   (w_rd_data),
        .o_par_err (w_par_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_use_nop    <= 1'b1;
            r_addr_fault <= 1'b0;
            r_ld_count   <= 16'd0;
        end else begin
            if (ld_valid && r_ld_count != 16'hFFFF) begin
                r_ld_count <= r_ld_count + 16'd1;
            end
            // An accepted fetch wins over flush so a redirect costs no bubble.
            if (w_accept) begin
                r_state      <= RESP;
                r_use_nop    <= w_fault;
                r_addr_fault <= w_fault;
            end else if (flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE:    if (ld_valid) r_state <= LOAD;
                    RESP:    if (rsp_ready && !ld_valid) r_state <= IDLE;
                    LOAD:    if (!ld_valid) r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_inst  = r_use_nop ? NOP : w_rd_data;
    assign rsp_fault = r_addr_fault || (!r_use_nop && w_par_err);
    assign ld_count  = r_ld_count;

endmodule

// File: tb/tb_imem_sync.sv
// Scoreboard bench for imem_sync: the driver queues expected responses, a monitor checks them.
// Build with IMEM_PARITY_EN to include the corrupted-word parity case.
module tb_imem_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic        rsp_fault;
    logic        flush;
    logic        ld_valid;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic [15:0] ld_count;

    localparam logic [31:0] NOPW = 32'h00000013;

    typedef struct {
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic acc_prev = 1'b0;

    imem_sync #(.DEPTH(1024), .ADDR_W(32), .NOP(NOPW)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_inst    (rsp_inst),
        .rsp_fault   (rsp_fault),
        .flush       (flush),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_count    (ld_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Latency: every accepted fetch must be presented on the very next cycle.
    always @(posedge clk) acc_prev <= !rst && fetch_req && fetch_ready;
    always @(negedge clk) if (acc_prev) chk("latency_rsp_valid", {31'b0, rsp_valid}, 32'd1);

    // Monitor: a response taken by the consumer (and not flushed) is scored.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", rsp_inst, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("rsp inst=%h fault=%b (exp %h/%b)", rsp_inst, rsp_fault, e.inst, e.fault);
                chk("rsp_inst", rsp_inst, e.inst);
                chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef,
                            input bit keep, output int n);
        exp_t e;
        n = 0;
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        while (!fetch_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!fetch_ready) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout addr=%h actual=not_accepted required=accepted", a);
        end else if (keep) begin
            e.inst  = ei;
            e.fault = ef;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
    endtask

    task automatic load_word(input logic [9:0] idx, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_addr  = idx;
        ld_data  = d;
        @(negedge clk);
        chk("ld_blocks_ready", {31'b0, fetch_ready}, 32'd0);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; rsp_ready = 1'b1;
        flush = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        ld_valid = 1'b1; ld_addr = 10'd0; ld_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rst_ready_ld", {31'b0, fetch_ready}, 32'd0);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        @(negedge clk);
        chk("rst_ld_count", {16'b0, ld_count}, 32'd0);
        chk("rst_ready", {31'b0, fetch_ready}, 32'd1);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_inst", rsp_inst, NOPW);
        chk("rst_fault", {31'b0, rsp_fault}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        load_word(10'd0, 32'h000010B7);
        load_word(10'd1, 32'h00001117);
        load_word(10'd2, 32'h010001EF);
        load_word(10'd3, 32'h00510113);
        @(negedge clk);
        chk("ld_count_4", {16'b0, ld_count}, 32'd4);
        @(posedge clk); #1;

        // Back-to-back fetches: each must be accepted without waiting.
        do_fetch(32'h0, 32'h000010B7, 1'b0, 1'b1, n);
        do_fetch(32'h4, 32'h00001117, 1'b0, 1'b1, n); chk("b2b_wait_4", n, 0);
        do_fetch(32'h8, 32'h010001EF, 1'b0, 1'b1, n); chk("b2b_wait_8", n, 0);
        do_fetch(32'hC, 32'h00510113, 1'b0, 1'b1, n); chk("b2b_wait_c", n, 0);
        @(posedge clk); #1;

        // Stall: response held stable, next fetch blocked until rsp_ready rises.
        do_fetch(32'h8, 32'h010001EF, 1'b0, 1'b1, n);
        rsp_ready = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_inst", rsp_inst, 32'h010001EF);
            chk("stall_ready", {31'b0, fetch_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        do_fetch(32'h0, 32'h000010B7, 1'b0, 1'b1, n);
        chk("accept_on_release", n, 0);

        // Faults, plus the last in-range word.
        do_fetch(32'h6, NOPW, 1'b1, 1'b1, n);
        do_fetch(32'h1000, NOPW, 1'b1, 1'b1, n);
        do_fetch(32'h80000000, NOPW, 1'b1, 1'b1, n);
        @(posedge clk); #1;
        load_word(10'd1023, 32'hDEADBEEF);
        do_fetch(32'hFFC, 32'hDEADBEEF, 1'b0, 1'b1, n);

        // Flush with a simultaneous redirect fetch.
        do_fetch(32'h4, 32'h0, 1'b0, 1'b0, n);
        flush = 1'b1;
        do_fetch(32'hC, 32'h00510113, 1'b0, 1'b1, n);
        flush = 1'b0;
        @(posedge clk); #1;

        // Flush alone during a stall drops the response.
        do_fetch(32'h0, 32'h0, 1'b0, 1'b0, n);
        rsp_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("flush_drop_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;

        // Load while a fetch is pending.
        fetch_req = 1'b1; fetch_addr = 32'h4;
        load_word(10'd5, 32'h00A00093);
        load_word(10'd6, 32'h00B00113);
        do_fetch(32'h4, 32'h00001117, 1'b0, 1'b1, n);
        chk("fetch_after_load_wait", n, 1);
        do_fetch(32'h14, 32'h00A00093, 1'b0, 1'b1, n);
        @(negedge clk);
        chk("ld_count_7", {16'b0, ld_count}, 32'd7);
        @(posedge clk); #1;

`ifdef IMEM_PARITY_EN
        dut.u_array.r_mem[2] = dut.u_array.r_mem[2] ^ 33'h1;
        do_fetch(32'h8, 32'h010001EE, 1'b1, 1'b1, n);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
